// File: rtl/kalman_step_scheduler.sv
// kalman_step_scheduler: scalar Kalman predict/update sequencer owning x and P,
// with a 16-cycle restoring divider for the gain and a shared external multiplier.
module kalman_step_scheduler #(
    parameter logic        [15:0] P_INIT = 16'h7FFF,
    parameter logic signed [15:0] X_INIT = 16'sh0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] z,
    input  logic        z_valid,
    input  logic [15:0] q_noise,
    input  logic [15:0] r_noise,
    output logic        mul_req,
    output logic [16:0] mul_a,
    output logic [16:0] mul_b,
    input  logic        mul_ack,
    input  logic [33:0] mul_p,
    output logic [15:0] x,
    output logic        x_valid,
    output logic [15:0] p_out,
    output logic        busy,
    output logic        overrun
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PREDICT = 3'd1;
    localparam logic [2:0] S_DIVIDE  = 3'd2;
    localparam logic [2:0] S_MUL_X   = 3'd3;
    localparam logic [2:0] S_MUL_P   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [15:0] x_q, x_d;
    logic [15:0] p_q, p_d;
    logic [15:0] z_q, z_d;
    logic [15:0] pend_q, pend_d;
    logic        pend_full_q, pend_full_d;
    logic [15:0] pp_q, pp_d;
    logic [16:0] den_q, den_d;
    logic [15:0] e_q, e_d;
    logic [16:0] rem_q, rem_d;
    logic [15:0] dvd_q, dvd_d;
    logic [15:0] quo_q, quo_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [16:0]        sum17;
    logic [15:0]        pp_new;
    logic [16:0]        den_new;
    logic [33:0]        diff;
    logic [17:0]        trial;
    logic               ge;
    logic [15:0]        k;
    logic signed [33:0] prod_sh;
    logic [33:0]        xsum;
    logic               take_pend;

    function automatic logic [15:0] sat16(input logic [33:0] v);
        logic signed [33:0] s;
        s = $signed(v);
        if (s > 34'sd32767)
            sat16 = 16'h7FFF;
        else if (s < -34'sd32768)
            sat16 = 16'h8000;
        else
            sat16 = v[15:0];
    endfunction

    always_comb begin
        sum17   = {1'b0, p_q} + {1'b0, q_noise};
        pp_new  = sum17[16] ? 16'hFFFF : sum17[15:0];
        den_new = {1'b0, pp_new} + {1'b0, r_noise};
        diff    = {{18{z_q[15]}}, z_q} - {{18{x_q[15]}}, x_q};
        trial   = {rem_q, dvd_q[15]};
        ge      = trial >= {1'b0, den_q};
        // den==0 also yields an all-ones quotient, so one clamp covers both
        k       = (den_q == 17'd0 || quo_q[15]) ? 16'h7FFF : quo_q;
        prod_sh = $signed(mul_p) >>> 15;
        xsum    = {{18{x_q[15]}}, x_q} + prod_sh;
    end

    assign take_pend = pend_full_q &&
                       (state_q == S_IDLE || state_q == S_DONE);

    assign busy    = state_q != S_IDLE;
    assign x_valid = state_q == S_DONE;
    assign x       = x_q;
    assign p_out   = p_q;
    assign overrun = z_valid && pend_full_q && !take_pend;

    assign mul_req = state_q == S_MUL_X || state_q == S_MUL_P;
    assign mul_a   = mul_req ? {1'b0, k} : 17'd0;

    always_comb begin
        mul_b = 17'd0;
        if (state_q == S_MUL_X)
            mul_b = {e_q[15], e_q};
        else if (state_q == S_MUL_P)
            mul_b = {1'b0, pp_q};
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        p_d         = p_q;
        z_d         = z_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        pp_d        = pp_q;
        den_d       = den_q;
        e_d         = e_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;

        if (take_pend)
            pend_full_d = 1'b0;
        if (z_valid && (state_q != S_IDLE || pend_full_q)) begin
            pend_d      = z;
            pend_full_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (take_pend) begin
                    z_d     = pend_q;
                    state_d = S_PREDICT;
                end else if (z_valid) begin
                    z_d     = z;
                    state_d = S_PREDICT;
                end
            end
            S_PREDICT: begin
                pp_d    = pp_new;
                den_d   = den_new;
                e_d     = sat16(diff);
                // top 15 dividend bits start the remainder; Pp[0] feeds first
                rem_d   = {2'b00, pp_new[15:1]};
                dvd_d   = {pp_new[0], 15'd0};
                quo_d   = 16'd0;
                cnt_d   = 4'd0;
                state_d = S_DIVIDE;
            end
            S_DIVIDE: begin
                rem_d = 17'(ge ? trial - {1'b0, den_q} : trial);
                dvd_d = {dvd_q[14:0], 1'b0};
                quo_d = {quo_q[14:0], ge};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15)
                    state_d = S_MUL_X;
            end
            S_MUL_X: begin
                if (mul_ack) begin
                    x_d     = sat16(xsum);
                    state_d = S_MUL_P;
                end
            end
            S_MUL_P: begin
                if (mul_ack) begin
                    p_d     = pp_q - mul_p[30:15];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (take_pend) begin
                    z_d     = pend_q;
                    state_d = S_PREDICT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            x_q         <= X_INIT;
            p_q         <= P_INIT;
            z_q         <= 16'd0;
            pend_q      <= 16'd0;
            pend_full_q <= 1'b0;
            pp_q        <= 16'd0;
            den_q       <= 17'd0;
            e_q         <= 16'd0;
            rem_q       <= 17'd0;
            dvd_q       <= 16'd0;
            quo_q       <= 16'd0;
            cnt_q       <= 4'd0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            p_q         <= p_d;
            z_q         <= z_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            pp_q        <= pp_d;
            den_q       <= den_d;
            e_q         <= e_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_kalman_step_scheduler.sv
// Scoreboard bench for kalman_step_scheduler: arithmetic reference model,
// randomized steps, stalling multiplier responder, negedge monitor.
module tb_kalman_step_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] z;
    logic        z_valid;
    logic [15:0] q_v, r_v;
    logic        mul_req, mul_ack;
    logic [16:0] mul_a, mul_b;
    logic [33:0] mul_p;
    logic [15:0] x, p_out;
    logic        x_valid, busy, overrun;

    logic        req0, xv0, busy0, ovr0;
    logic [16:0] a0s, b0s;
    logic [33:0] prod0;
    logic [15:0] x0, p0;
    logic        ack0 = 1'b1;

    kalman_step_scheduler #(.P_INIT(16'h0100), .X_INIT(16'sh0000)) dut (
        .clk(clk), .rst_n(rst_n), .z(z), .z_valid(z_valid),
        .q_noise(q_v), .r_noise(r_v),
        .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b),
        .mul_ack(mul_ack), .mul_p(mul_p),
        .x(x), .x_valid(x_valid), .p_out(p_out),
        .busy(busy), .overrun(overrun)
    );

    kalman_step_scheduler #(.P_INIT(16'h0000), .X_INIT(16'sh0000)) dut0 (
        .clk(clk), .rst_n(rst_n), .z(z), .z_valid(z_valid),
        .q_noise(q_v), .r_noise(r_v),
        .mul_req(req0), .mul_a(a0s), .mul_b(b0s),
        .mul_ack(ack0), .mul_p(prod0),
        .x(x0), .x_valid(xv0), .p_out(p0),
        .busy(busy0), .overrun(ovr0)
    );

    assign prod0 = {{17{a0s[16]}}, a0s} * {{17{b0s[16]}}, b0s};

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [15:0] p;
        int          cyc;
    } exp_t;

    exp_t   sbq[$];
    int     ovq[$];
    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     stall_x = 0;
    int     stall_p = 0;
    longint mx, mp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic longint clamp16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference: one full scalar Kalman step on the model state
    task automatic model_step(input logic [15:0] zz, input int c);
        longint pp, den, k, e, d;
        exp_t it;
        pp = mp + longint'(q_v);
        if (pp > 65535) pp = 65535;
        den = pp + longint'(r_v);
        if (den == 0) k = 32767;
        else begin
            k = (pp * 32768) / den;
            if (k > 32767) k = 32767;
        end
        e  = clamp16(longint'($signed(zz)) - mx);
        d  = (k * e) >>> 15;
        mx = clamp16(mx + d);
        mp = pp - ((k * pp) >> 15);
        it.x = mx[15:0];
        it.p = mp[15:0];
        it.cyc = c;
        sbq.push_back(it);
    endtask

    // Multiplier responder: waits stall cycles per request, checks hold
    initial begin
        int waited, phase, cur;
        logic [16:0] ha, hb;
        waited = 0; phase = 0; ha = '0; hb = '0;
        mul_ack = 1'b0;
        mul_p = '0;
        forever begin
            @(posedge clk);
            #1;
            cur = (phase != 0) ? stall_p : stall_x;
            if (!rst_n) begin
                waited = 0; phase = 0;
                mul_ack = 1'b0; mul_p = '0;
            end else if (mul_req) begin
                if (waited == 0) begin
                    ha = mul_a; hb = mul_b;
                end
                if (waited >= cur) begin
                    if (cur > 0) begin
                        chk("hold_a", mul_a, ha);
                        chk("hold_b", mul_b, hb);
                    end
                    mul_ack = 1'b1;
                    mul_p = {{17{mul_a[16]}}, mul_a} * {{17{mul_b[16]}}, mul_b};
                    waited = 0;
                    phase ^= 1;
                end else begin
                    mul_ack = 1'b0;
                    mul_p = '0;
                    waited++;
                end
            end else begin
                waited = 0;
                mul_ack = (stall_x == 0 && stall_p == 0);
                mul_p = {{17{mul_a[16]}}, mul_a} * {{17{mul_b[16]}}, mul_b};
            end
        end
    end

    // Monitor: pops expected results on x_valid / overrun
    always @(negedge clk) begin
        if (rst_n) begin
            if (x_valid) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_x_valid: x=%0h at cycle %0d", x, cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("x", x, e.x);
                    chk("p_out", p_out, e.p);
                    chk("x_valid_cycle", cyc, e.cyc);
                end
            end
            if (overrun) begin
                if (ovq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_overrun at cycle %0d", cyc);
                end else begin
                    int oc;
                    oc = ovq.pop_front();
                    chk("overrun_cycle", cyc, oc);
                end
            end
        end
    end

    task automatic step_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [15:0] zz);
        int c;
        c = cyc;
        z = zz;
        z_valid = 1'b1;
        model_step(zz, c + 20 + stall_x + stall_p);
        @(posedge clk);
        #1;
        z_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sbq.size() != 0 || busy) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) begin
            total++; bad++;
            $display("FAIL timeout: busy=%0b pending_exp=%0d", busy, sbq.size());
        end
    endtask

    // Mid-cycle reset: outputs must fall back at once
    task automatic async_rst();
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mul_req", mul_req, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        chk("rst_x", x, 0);
        chk("rst_p", p_out, 16'h0100);
        chk("rst_busy", busy, 0);
        chk("rst_x_valid", x_valid, 0);
        sbq.delete();
        ovq.delete();
        mx = 0;
        mp = 16'h0100;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int c;
        rst_n = 1'b0;
        z = '0;
        z_valid = 1'b0;
        q_v = '0;
        r_v = '0;
        mx = 0;
        mp = 16'h0100;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_x", x, 0);
        chk("reset_p", p_out, 16'h0100);
        chk("reset_busy", busy, 0);
        chk("reset_x_valid", x_valid, 0);
        chk("reset_mul_req", mul_req, 0);
        chk("reset_overrun", overrun, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // gain clamp (R=0) and den==0 on the P_INIT=0 instance
        q_v = 16'h0000;
        r_v = 16'h0000;
        c = cyc;
        issue(16'h1000);
        chk("busy_after_z", busy, 1);
        chk("busy0_after_z", busy0, 1);
        step_to(c + 18);
        chk("dut0_mul_req", req0, 1);
        step_to(c + 20);
        chk("dut0_x_valid", xv0, 1);
        chk("dut0_x", x0, 16'h0FFF);
        chk("dut0_p", p0, 16'h0000);
        wait_done();
        chk("clamp_x", x, 16'h0FFF);
        chk("clamp_p", p_out, 16'h0001);

        // basic step
        async_rst();
        r_v = 16'h0100;
        issue(16'h1000);
        wait_done();
        chk("basic_x", x, 16'h0800);
        chk("basic_p", p_out, 16'h0080);

        // multiplier stall
        async_rst();
        stall_x = 5;
        stall_p = 3;
        issue(16'h1000);
        wait_done();
        chk("stall_x", x, 16'h0800);
        stall_x = 0;
        stall_p = 0;

        // saturation: Pp clamp then large negative innovation
        async_rst();
        q_v = 16'hFFFF;
        r_v = 16'h0000;
        issue(16'h7FFF);
        wait_done();
        chk("sat_x_high", x, 16'h7FFE);
        q_v = 16'h0000;
        issue(16'h8000);
        wait_done();

        // back-to-back with overrun
        async_rst();
        r_v = 16'h0100;
        c = cyc;
        issue(16'h1000);
        step_to(c + 5);
        z = 16'h2222;
        z_valid = 1'b1;
        @(posedge clk);
        #1;
        z_valid = 1'b0;
        step_to(c + 9);
        z = 16'hF000;
        z_valid = 1'b1;
        ovq.push_back(c + 9);
        model_step(16'hF000, c + 40);
        #1;
        chk("dut0_overrun", ovr0, 1);
        @(posedge clk);
        #1;
        z_valid = 1'b0;
        wait_done();
        chk("overrun_seen", ovq.size(), 0);

        // reset during DIVIDE
        async_rst();
        c = cyc;
        issue(16'h1234);
        step_to(c + 8);
        chk("divide_busy", busy, 1);
        async_rst();

        // reset during a stalled MUL_X
        stall_x = 10;
        c = cyc;
        issue(16'h1234);
        step_to(c + 19);
        chk("mulx_req_before_rst", mul_req, 1);
        async_rst();
        stall_x = 0;
        repeat (25) @(posedge clk);
        #1;
        issue(16'h0400);
        wait_done();

        // randomized steps
        for (int i = 0; i < 25; i++) begin
            q_v = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 16'h0800));
            r_v = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
            stall_x = $urandom_range(0, 3);
            stall_p = $urandom_range(0, 3);
            issue(16'($urandom));
            wait_done();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        stall_x = 0;
        stall_p = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
